// File: rtl/gpr_file.sv
// 32 x 64-bit general-purpose register file: two registered read ports, two write ports.
// Reads return pre-write contents, and port 1 wins a same-address double write.
module gpr_file #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ren0,
    input  logic [ADDR_W-1:0] raddr0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              ren1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              wen0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              wen1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1
);

    // Vectors run [W-1:0]: architectural bit 0 (MSB) is vector bit DATA_W-1.
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            // Port 1 is checked first so it overrides port 0 on an address collision.
            always_comb begin
                regs_d[gi] = regs_q[gi];
                if (wen1 && (waddr1 == ADDR_W'(gi))) begin
                    regs_d[gi] = wdata1;
                end else if (wen0 && (waddr0 == ADDR_W'(gi))) begin
                    regs_d[gi] = wdata0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    regs_q[gi] <= '0;
                end else begin
                    regs_q[gi] <= regs_d[gi];
                end
            end
        end
    endgenerate

    // Reads sample regs_q, so a same-edge write is not yet visible.
    always_comb begin
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        if (ren0) begin
            rdata0_d = regs_q[raddr0];
        end
        if (ren1) begin
            rdata1_d = regs_q[raddr1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_gpr_file.sv
// Bench for gpr_file: directed scenarios followed by random traffic, all
// checked against an array-based reference model of the register file.
module tb_gpr_file;

    logic        clk;
    logic        rst_n;
    logic        ren0, ren1, wen0, wen1;
    logic [4:0]  raddr0, raddr1, waddr0, waddr1;
    logic [63:0] wdata0, wdata1;
    logic [63:0] rdata0, rdata1;

    int checks = 0;
    int errors = 0;

    logic [63:0] model [32];
    logic [63:0] exp0, exp1;

    gpr_file dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ren0   (ren0),
        .raddr0 (raddr0),
        .rdata0 (rdata0),
        .ren1   (ren1),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .wen0   (wen0),
        .waddr0 (waddr0),
        .wdata0 (wdata0),
        .wen1   (wen1),
        .waddr1 (waddr1),
        .wdata1 (wdata1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic r0, input logic [4:0] ra0, input logic r1, input logic [4:0] ra1,
                         input logic w0, input logic [4:0] wa0, input logic [63:0] wd0,
                         input logic w1, input logic [4:0] wa1, input logic [63:0] wd1);
        ren0 = r0; raddr0 = ra0; ren1 = r1; raddr1 = ra1;
        wen0 = w0; waddr0 = wa0; wdata0 = wd0;
        wen1 = w1; waddr1 = wa1; wdata1 = wd1;
    endtask

    // Apply one clock edge to the model (reads see old contents, port 1 written last),
    // then let the DUT take the same edge and stop on the following falling edge.
    task automatic tick();
        if (ren0) exp0 = model[raddr0];
        if (ren1) exp1 = model[raddr1];
        if (wen0) model[waddr0] = wdata0;
        if (wen1) model[waddr1] = wdata1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 64'h0, 0, 0, 64'h0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = 64'h0;
        exp0 = 64'h0;
        exp1 = 64'h0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();
        #1;
        check("reset_rdata0", rdata0, 64'h0);
        check("reset_rdata1", rdata1, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while running: rdata clears without a clock edge, contents cleared.
        drive(0, 0, 0, 0, 1, 5, 64'hDEAD, 0, 0, 64'h0); tick();
        drive(1, 5, 1, 5, 0, 0, 64'h0, 0, 0, 64'h0); tick();
        check("pre_reset_rd0", rdata0, 64'hDEAD);
        check("pre_reset_rd1", rdata1, 64'hDEAD);
        idle();
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_rd0", rdata0, 64'h0);
        check("async_reset_rd1", rdata1, 64'h0);
        model_reset();
        #1 rst_n = 1'b1;
        @(negedge clk);
        drive(1, 5, 0, 0, 0, 0, 64'h0, 0, 0, 64'h0); tick();
        check("r5_after_reset", rdata0, 64'h0);
        $display("txn reset: r5 after reset = %h", rdata0);

        // Write then read with one-cycle latency, then hold while ren0 is low.
        drive(0, 0, 0, 0, 1, 3, 64'h0123456789ABCDEF, 0, 0, 64'h0); tick();
        drive(1, 3, 0, 0, 0, 0, 64'h0, 0, 0, 64'h0); tick();
        check("read_r3", rdata0, 64'h0123456789ABCDEF);
        for (int i = 0; i < 3; i++) begin
            drive(0, 3, 0, 0, 1, 3, 64'h1111 * (i + 1), 0, 0, 64'h0); tick();
            check("hold_rdata0", rdata0, 64'h0123456789ABCDEF);
        end
        $display("txn hold: rdata0 = %h", rdata0);

        // Dual write to different registers on one edge.
        drive(0, 0, 0, 0, 1, 1, 64'h11, 1, 2, 64'h22); tick();
        drive(1, 1, 1, 2, 0, 0, 64'h0, 0, 0, 64'h0); tick();
        check("dual_r1", rdata0, 64'h11);
        check("dual_r2", rdata1, 64'h22);
        $display("txn dual write: r1=%h r2=%h", rdata0, rdata1);

        // Collision: port 1 wins.
        drive(0, 0, 0, 0, 1, 7, 64'hAA, 1, 7, 64'hBB); tick();
        drive(1, 7, 1, 7, 0, 0, 64'h0, 0, 0, 64'h0); tick();
        check("collide_rd0", rdata0, 64'hBB);
        check("collide_rd1", rdata1, 64'hBB);
        $display("txn collision: r7=%h", rdata0);

        // Read-before-write on the same edge.
        drive(0, 0, 0, 0, 1, 9, 64'h5, 0, 0, 64'h0); tick();
        drive(1, 9, 1, 9, 0, 0, 64'h0, 1, 9, 64'h6); tick();
        check("rbw_old_rd0", rdata0, 64'h5);
        check("rbw_old_rd1", rdata1, 64'h5);
        drive(1, 9, 0, 0, 0, 0, 64'h0, 0, 0, 64'h0); tick();
        check("rbw_new", rdata0, 64'h6);
        $display("txn read-before-write: r9 now %h", rdata0);

        // Register 0 is ordinary storage.
        drive(0, 0, 0, 0, 1, 0, 64'hFFFFFFFFFFFFFFFF, 0, 0, 64'h0); tick();
        drive(1, 0, 1, 0, 0, 0, 64'h0, 0, 0, 64'h0); tick();
        check("r0_rd0", rdata0, 64'hFFFFFFFFFFFFFFFF);
        check("r0_rd1", rdata1, 64'hFFFFFFFFFFFFFFFF);
        $display("txn r0: %h", rdata0);

        // Random traffic; narrow address range half the time to force collisions.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] amask;
            amask = ($urandom_range(0, 1) == 0) ? 5'h03 : 5'h1F;
            drive($urandom_range(0, 1), 5'($urandom) & amask,
                  $urandom_range(0, 1), 5'($urandom) & amask,
                  $urandom_range(0, 1), 5'($urandom) & amask, {$urandom, $urandom},
                  $urandom_range(0, 1), 5'($urandom) & amask, {$urandom, $urandom});
            tick();
            check("rand_rd0", rdata0, exp0);
            check("rand_rd1", rdata1, exp1);
        end
        $display("txn random: 400 cycles done");

        // Final sweep of every register against the model.
        for (int r = 0; r < 32; r++) begin
            drive(1, 5'(r), 1, 5'(31 - r), 0, 0, 64'h0, 0, 0, 64'h0); tick();
            check("sweep_rd0", rdata0, exp0);
            check("sweep_rd1", rdata1, exp1);
        end
        $display("txn sweep: all registers read");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
